// File: rtl/conv_wb_pkg.sv
// Shared definitions for the convolution result write-back stage:
// FSM state encoding and default geometry constants.
package conv_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_WRITE   = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PACK   = 4;
    localparam int DEF_TOTAL  = 43;

endpackage

// File: rtl/res_pack_reg.sv
// Lane register that packs individual results into one memory word, with a
// per-lane valid bit that doubles as the write byte enable.
module res_pack_reg #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4,
    parameter int LANE_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [LANE_W-1:0]      wr_lane,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [PACK*DATA_W-1:0] lanes,
    output logic [PACK-1:0]        lane_vld
);

    // Clear wins over write so unfilled lanes of the next word start at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes    <= '0;
            lane_vld <= '0;
        end else if (clr) begin
            lanes    <= '0;
            lane_vld <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < PACK; i++) begin
                if (wr_lane == LANE_W'(i)) begin
                    lanes[i*DATA_W +: DATA_W] <= wr_data;
                    lane_vld[i]               <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Write-back stage: packs PACK results per word, writes words to consecutive
// addresses, flushes the final partial word and pulses done.
module conv_result_writer
    import conv_wb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PACK      = DEF_PACK,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int TOTAL     = DEF_TOTAL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   res_valid,
    input  logic [DATA_W-1:0]      res_data,
    output logic                   res_ready,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [PACK*DATA_W-1:0] mem_wdata,
    output logic [PACK-1:0]        mem_byte_en,
    input  logic                   mem_ready,
    output logic                   done
);

    localparam int                LANE_W    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
    localparam logic [7:0]        LAST_RES  = 8'(TOTAL - 1);
    localparam logic [7:0]        TOTAL_CNT = 8'(TOTAL);

    state_t            state;
    logic [LANE_W-1:0] lane_cnt;
    logic [7:0]        res_cnt;
    logic              accept;
    logic              last_xfer;
    logic              wr_done;
    logic              lane_clr;

    assign accept    = (state == ST_COLLECT) && res_valid;
    assign last_xfer = (lane_cnt == LAST_LANE) || (res_cnt == LAST_RES);
    assign wr_done   = (state == ST_WRITE) && mem_ready;
    assign lane_clr  = ((state == ST_IDLE) && start) || wr_done;

    res_pack_reg #(
        .DATA_W (DATA_W),
        .PACK   (PACK),
        .LANE_W (LANE_W)
    ) u_pack (
        .clk      (clk),
        .rst      (rst),
        .clr      (lane_clr),
        .wr_en    (accept),
        .wr_lane  (lane_cnt),
        .wr_data  (res_data),
        .lanes    (mem_wdata),
        .lane_vld (mem_byte_en)
    );

    // Handshake outputs are registered alongside the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lane_cnt  <= '0;
            res_cnt   <= '0;
            mem_addr  <= BASE;
            res_ready <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        lane_cnt  <= '0;
                        res_cnt   <= '0;
                        mem_addr  <= BASE;
                        res_ready <= 1'b1;
                        state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (res_valid) begin
                        res_cnt <= res_cnt + 8'd1;
                        // lane_cnt holds on the last lane and clears once the write lands.
                        if (last_xfer) begin
                            res_ready <= 1'b0;
                            mem_wr_en <= 1'b1;
                            state     <= ST_WRITE;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_wr_en <= 1'b0;
                        mem_addr  <= mem_addr + 1'b1;
                        lane_cnt  <= '0;
                        if (res_cnt == TOTAL_CNT) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            res_ready <= 1'b1;
                            state     <= ST_COLLECT;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer: expected writes/done events are
// queued by the stimulus and consumed by per-instance output monitors.
module tb_conv_result_writer;

    typedef struct packed {
        logic        is_done;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Main instance, TOTAL = 43
    logic        start = 1'b0, res_valid = 1'b0, mem_ready = 1'b1;
    logic [7:0]  res_data = '0;
    logic        res_ready, mem_wr_en, done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;

    // TOTAL = 4 instance
    logic        s4_start = 1'b0, s4_valid = 1'b0;
    logic [7:0]  s4_data = '0;
    logic        s4_ready, s4_wr, s4_done;
    logic [7:0]  s4_addr;
    logic [31:0] s4_wdata;
    logic [3:0]  s4_be;

    // TOTAL = 1 instance
    logic        s1_start = 1'b0, s1_valid = 1'b0;
    logic [7:0]  s1_data = '0;
    logic        s1_ready, s1_wr, s1_done;
    logic [7:0]  s1_addr;
    logic [31:0] s1_wdata;
    logic [3:0]  s1_be;

    exp_t q0[$];
    exp_t q4[$];
    exp_t q1[$];
    int   la0 = -10, la4 = -10, la1 = -10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_result_writer #(.TOTAL(43)) dut (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_ready(mem_ready), .done(done)
    );

    conv_result_writer #(.TOTAL(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .res_valid(s4_valid), .res_data(s4_data),
        .res_ready(s4_ready), .mem_wr_en(s4_wr), .mem_addr(s4_addr),
        .mem_wdata(s4_wdata), .mem_byte_en(s4_be), .mem_ready(1'b1), .done(s4_done)
    );

    conv_result_writer #(.TOTAL(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .res_valid(s1_valid), .res_data(s1_data),
        .res_ready(s1_ready), .mem_wr_en(s1_wr), .mem_addr(s1_addr),
        .mem_wdata(s1_wdata), .mem_byte_en(s1_be), .mem_ready(1'b1), .done(s1_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic mon(input string tag, ref exp_t q[$], ref int last_acc,
                       input logic wr, input logic rdy, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input logic dn);
        exp_t e;
        if (wr && rdy) begin
            if (q.size() == 0) begin
                check({tag, "_unexpected_write"}, 64'(addr), 64'hFFFF);
            end else begin
                e = q.pop_front();
                check({tag, "_kind"}, 64'(0), 64'(e.is_done));
                check($sformatf("%s_addr%0d", tag, e.addr), 64'(addr), 64'(e.addr));
                check($sformatf("%s_data%0d", tag, e.addr), 64'(data), 64'(e.data));
                check($sformatf("%s_be%0d", tag, e.addr), 64'(be), 64'(e.be));
            end
            last_acc = cyc;
        end
        if (dn) begin
            if (q.size() == 0) begin
                check({tag, "_unexpected_done"}, 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                check({tag, "_done_kind"}, 64'(1), 64'(e.is_done));
                check({tag, "_done_gap"}, 64'(cyc - last_acc), 64'(1));
            end
        end
    endtask

    always @(negedge clk) mon("main", q0, la0, mem_wr_en, mem_ready, mem_addr, mem_wdata, mem_byte_en, done);
    always @(negedge clk) mon("t4", q4, la4, s4_wr, 1'b1, s4_addr, s4_wdata, s4_be, s4_done);
    always @(negedge clk) mon("t1", q1, la1, s1_wr, 1'b1, s1_addr, s1_wdata, s1_be, s1_done);

    // Results are the values 1..n, four per word, lane 0 in the low byte.
    task automatic push_image(input int n);
        logic [31:0] d;
        logic [3:0]  b;
        for (int w = 0; w < (n + 3) / 4; w++) begin
            d = '0;
            b = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j + 1 <= n) begin
                    d[j*8 +: 8] = 8'(4 * w + j + 1);
                    b[j] = 1'b1;
                end
            end
            q0.push_back({1'b0, 8'(w), d, b});
        end
        q0.push_back({1'b1, 8'h00, 32'h0, 4'h0});
    endtask

    task automatic start_img(input string name);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_start_accept"}, 64'(res_ready), 64'(1));
    endtask

    task automatic feed(input int n, input bit bubbles);
        int b;
        for (int k = 1; k <= n; k++) begin
            if (bubbles) begin
                while ($urandom_range(0, 2) == 0) begin
                    res_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            res_valid = 1'b1;
            res_data  = 8'(k);
            b = 0;
            while (!res_ready && b < 100) begin
                @(posedge clk); #1;
                b++;
            end
            if (!res_ready) timeout("res_ready_wait");
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int b = 0;
        while (!done && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (!done) timeout({name, "_done_wait"});
        @(posedge clk); #1;
    endtask

    task automatic bp_word2();
        int b = 0;
        while (mem_addr != 8'd2 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        mem_ready = 1'b0;
        b = 0;
        while (!mem_wr_en && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        if (!mem_wr_en) timeout("bp_wr_wait");
        for (int c = 0; c < 5; c++) begin
            check("bp_wr_en", 64'(mem_wr_en), 64'(1));
            check("bp_addr", 64'(mem_addr), 64'(2));
            check("bp_data", 64'(mem_wdata), 64'h0C0B0A09);
            check("bp_res_ready", 64'(res_ready), 64'(0));
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
    endtask

    task automatic stray_starts();
        int b = 0;
        while (!mem_wr_en && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b = 0;
        while (!res_ready && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_ready", 64'(res_ready), 64'(0));
        check("rst_wr_en", 64'(mem_wr_en), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_be", 64'(mem_byte_en), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Abort mid-image: word 0 written, two lanes of word 1 filled.
        q0.push_back({1'b0, 8'd0, 32'h04030201, 4'b1111});
        start_img("abort");
        feed(6, 1'b0);
        check("abort_be_before", 64'(mem_byte_en), 64'(4'b0011));
        check("abort_ready_before", 64'(res_ready), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("abort_res_ready", 64'(res_ready), 64'(0));
        check("abort_wr_en", 64'(mem_wr_en), 64'(0));
        check("abort_addr", 64'(mem_addr), 64'(0));
        check("abort_wdata", 64'(mem_wdata), 64'(0));
        check("abort_be", 64'(mem_byte_en), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_queue_empty", 64'(q0.size()), 64'(0));

        push_image(43);
        start_img("full");
        feed(43, 1'b0);
        wait_done("full");

        push_image(43);
        start_img("bp");
        fork
            feed(43, 1'b0);
            bp_word2();
        join
        wait_done("bp");

        push_image(43);
        start_img("bubble");
        feed(43, 1'b1);
        wait_done("bubble");

        push_image(43);
        start_img("stray");
        fork
            feed(43, 1'b0);
            stray_starts();
        join
        wait_done("stray");

        push_image(43);
        start_img("again");
        feed(43, 1'b1);
        wait_done("again");

        q4.push_back({1'b0, 8'd0, 32'h04030201, 4'b1111});
        q4.push_back({1'b1, 8'h00, 32'h0, 4'h0});
        s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        s4_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s4_data = 8'(k);
            @(posedge clk); #1;
        end
        s4_valid = 1'b0;

        q1.push_back({1'b0, 8'd0, 32'h000000A5, 4'b0001});
        q1.push_back({1'b1, 8'h00, 32'h0, 4'h0});
        s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        s1_valid = 1'b1;
        s1_data  = 8'hA5;
        @(posedge clk); #1;
        s1_valid = 1'b0;

        repeat (20) @(posedge clk);
        #1;
        check("main_queue_empty", 64'(q0.size()), 64'(0));
        check("t4_queue_empty", 64'(q4.size()), 64'(0));
        check("t1_queue_empty", 64'(q1.size()), 64'(0));
        check("t1_idle_ready", 64'(s1_ready), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Downstream write-back stage of the convolution accelerator. Takes the stream of 8-bit convolution results emitted by the datapath's result-buffer stage, packs PACK results per memory word, and writes the packed words to output memory at consecutive addresses. After TOTAL results, it flushes a final partial word and pulses `done`.

## Interface
- `DATA_W`, default 8: width of one result.
- `PACK`, default 4: results per memory word.
- `ADDR_W`, default 8: output memory address width.
- `BASE_ADDR`, default 0: address of the first written word.
- `TOTAL`, default 43: results per image; range 1..255.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous and active-high. All state and outputs go to reset values immediately.
- `start  in  1`: one-cycle pulse that arms the block for a new image.
- `res_valid  in  1`: result present on `res_data`.
- `res_data  in  DATA_W`: result value.
- `res_ready  out  1`: block accepts a result this cycle. Reset 0.
- `mem_wr_en  out  1`: write request. Reset 0.
- `mem_addr  out  ADDR_W`: write address. Reset `BASE_ADDR`.
- `mem_wdata  out  PACK*DATA_W`: packed word. Lane i occupies bits [i*DATA_W +: DATA_W]. Reset 0.
- `mem_byte_en  out  PACK`: one bit per filled lane. Reset 0.
- `mem_ready  in  1`: memory accepts the write this cycle.
- `done  out  1`: one-cycle completion pulse. Reset 0.

## Operation
- The state machine has four states: IDLE, COLLECT, WRITE, DONE. Reset state is IDLE.
- IDLE:
  - `res_ready` = 0.
  - On `start`: clear lane count, result count and lanes; set `mem_addr` = `BASE_ADDR`; go to COLLECT.
- COLLECT:
  - `res_ready` = 1.
  - A result transfers when `res_valid` is high. It is stored in lane `lane_cnt`, the matching `mem_byte_en` bit is set, and both `lane_cnt` and `res_cnt` increment.
  - If the transfer fills lane PACK-1, or is result TOTAL, go to WRITE. Otherwise stay in COLLECT.
- WRITE:
  - `res_ready` = 0 and `mem_wr_en` = 1.
  - `mem_addr`, `mem_wdata` and `mem_byte_en` are held stable until `mem_ready`.
  - In the `mem_ready` cycle, the write completes. `mem_addr` increments (wraps modulo 2^ADDR_W), and lanes, `mem_byte_en` and `lane_cnt` clear.
  - Next state is DONE if `res_cnt` == TOTAL, else COLLECT.
- DONE: `done` = 1 for one cycle, then IDLE.
- Lane rules:
  - Unfilled lanes of a partial word are 0.
  - `lane_cnt` counts 0..PACK-1. `res_cnt` is 8 bits and never exceeds TOTAL.
- `start` outside IDLE is ignored.
- `res_valid` outside COLLECT is ignored; the upstream stage holds the result until `res_ready`.
- `rst` mid-image aborts without a flush. The partial word is discarded and no `done` is issued.
- Defaults give 10 full words plus 1 word with 3 lanes (`mem_byte_en` = 4'b0111). That is 11 writes at BASE..BASE+10.

## Timing
- A result accepted in cycle T that completes a word produces `mem_wr_en` high in cycle T+1, since outputs come from registered state.
- Minimum write duration is 1 cycle (`mem_ready` tied high). Peak throughput is PACK results per PACK+1 cycles.
- `done` is asserted the cycle after the final write is accepted.
- After `done`, the block accepts `start` in the following cycle.
- All outputs are registered or decoded from the registered state only; nothing is combinational from inputs.

## Structure
- Shared package `conv_wb_pkg` holds:
  - the state encoding (IDLE=2'b00, COLLECT=2'b01, WRITE=2'b10, DONE=2'b11);
  - default constants DATA_W, PACK, TOTAL.
- Single sub-module `res_pack_reg`: PACK lanes with a lane-indexed write enable, per-lane valid bits (driving `mem_byte_en`), and a synchronous clear plus asynchronous reset.
- Top-level logic comprises the FSM, lane/result counters and the address register.

## Test plan
- Reset: assert `rst` mid-COLLECT with 2 lanes filled. All outputs return to reset values in the same cycle, with no write and no `done`.
- Full image, `mem_ready` tied 1: send results 1..43 back to back. Required response:
  - 11 writes at addresses 0..10;
  - word 0 = 32'h04030201, word 10 = 32'h002B2A29 with byte_en 4'b0111;
  - `done` one cycle after the last write.
- Backpressure: hold `mem_ready` low 5 cycles on word 2. `mem_wr_en`, address 2 and data 32'h0C0B0A09 stay stable, `res_ready` stays 0, and no result is lost.
- Bubbled input: toggle `res_valid` randomly. Output words are identical to the back-to-back case.
- Edge TOTAL: TOTAL=4 gives one write with byte_en 4'b1111. TOTAL=1 gives one write of 32'h000000xx with byte_en 4'b0001.
- Ignored start: pulse `start` during WRITE and COLLECT. There is no restart and the counts are unaffected. A second image after `done` restarts at `BASE_ADDR`.
